// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_data_t;

  localparam int        NUM_REGS = 32;
  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: N-wide one-hot grant, search starts at the pointer
// and wraps. The pointer moves just past the winner on every grant.
// Grants are suppressed while rst is high.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic          o_gnt_vld,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;

  // Pick the first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    int j;
    j         = 0;
    o_gnt     = '0;
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(r_ptr) + k) % N;
      if (!rst && !o_gnt_vld && i_req[j]) begin
        o_gnt[j]  = 1'b1;
        o_gnt_vld = 1'b1;
        o_gnt_idx = IW'(j);
      end
    end
  end

  // Advance the pointer past the winner; hold it when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: shares the register file write port among NUM_REQ
// requesters (round-robin, valid/ready) and tracks pending destination
// registers so the issue stage can see RAW hazards on rs1/rs2.
// Optional macro WB_SCHED_BYPASS_EN adds fwd1/fwd2 forwarding ports that
// cover the register file returning stale data on a same-edge read/write.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*RF_AW-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  input  logic                     resv_valid,
  input  logic [RF_AW-1:0]         resv_addr,
  input  logic [RF_AW-1:0]         query_rs1,
  input  logic [RF_AW-1:0]         query_rs2,
  output logic                     hz_rs1,
  output logic                     hz_rs2,
  output logic                     rf_readWrite,
  output logic [RF_AW-1:0]         rf_addr_write,
  output logic [XLEN-1:0]          rf_write_data,
  output logic [NUM_REGS-1:0]      pending_mask
`ifdef WB_SCHED_BYPASS_EN
  ,
  output logic                     fwd1_valid,
  output logic [XLEN-1:0]          fwd1_data,
  output logic                     fwd2_valid,
  output logic [XLEN-1:0]          fwd2_data
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_vld;
  logic [IW-1:0]       w_gnt_idx;
  logic [RF_AW-1:0]    w_sel_addr;
  logic [XLEN-1:0]     w_sel_data;
  logic                w_wr;
  logic [NUM_REGS-1:0] w_mask_nxt;

  logic                r_rf_we_p1;
  logic [RF_AW-1:0]    r_rf_addr_p1;
  logic [XLEN-1:0]     r_rf_data_p1;
  logic [NUM_REGS-1:0] r_mask;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  // ---- stage p0: grant, operand select, scoreboard next state ----
  assign req_ready  = w_gnt;
  assign w_sel_addr = req_addr[int'(w_gnt_idx)*RF_AW +: RF_AW];
  assign w_sel_data = req_data[int'(w_gnt_idx)*XLEN +: XLEN];
  // x0 writes are accepted but never reach the register file.
  assign w_wr       = w_gnt_vld && (w_sel_addr != REG_ZERO);

  // Clear the retiring register, then set a new reservation so it wins ties.
  always_comb begin
    w_mask_nxt = r_mask;
    if (w_wr) begin
      w_mask_nxt[w_sel_addr] = 1'b0;
    end
    if (resv_valid && (resv_addr != REG_ZERO)) begin
      w_mask_nxt[resv_addr] = 1'b1;
    end
    w_mask_nxt[0] = 1'b0;
  end

  // ---- stage p1: registered register-file write port and scoreboard ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we_p1   <= 1'b0;
      r_rf_addr_p1 <= '0;
      r_rf_data_p1 <= '0;
      r_mask       <= '0;
    end else begin
      r_rf_we_p1 <= w_wr;
      r_mask     <= w_mask_nxt;
      if (w_wr) begin
        r_rf_addr_p1 <= w_sel_addr;
        r_rf_data_p1 <= w_sel_data;
      end
    end
  end

  assign rf_readWrite  = r_rf_we_p1;
  assign rf_addr_write = r_rf_addr_p1;
  assign rf_write_data = r_rf_data_p1;
  assign pending_mask  = r_mask;

  assign hz_rs1 = (query_rs1 != REG_ZERO) && r_mask[query_rs1];
  assign hz_rs2 = (query_rs2 != REG_ZERO) && r_mask[query_rs2];

`ifdef WB_SCHED_BYPASS_EN
  assign fwd1_valid = r_rf_we_p1 && (r_rf_addr_p1 == query_rs1) && (query_rs1 != REG_ZERO);
  assign fwd1_data  = fwd1_valid ? r_rf_data_p1 : '0;
  assign fwd2_valid = r_rf_we_p1 && (r_rf_addr_p1 == query_rs2) && (query_rs2 != REG_ZERO);
  assign fwd2_data  = fwd2_valid ? r_rf_data_p1 : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: table of vectors with expected grants,
// scoreboard queue of expected register-file writes, model of the mask.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        resv_valid;
  logic [4:0]  resv_addr;
  logic [4:0]  query_rs1, query_rs2;
  logic        hz_rs1, hz_rs2;
  logic        rf_readWrite;
  logic [4:0]  rf_addr_write;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;
`ifdef WB_SCHED_BYPASS_EN
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  regfile_wb_scheduler #(.NUM_REQ(3), .XLEN(32), .RF_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .resv_valid    (resv_valid),
    .resv_addr     (resv_addr),
    .query_rs1     (query_rs1),
    .query_rs2     (query_rs2),
    .hz_rs1        (hz_rs1),
    .hz_rs2        (hz_rs2),
    .rf_readWrite  (rf_readWrite),
    .rf_addr_write (rf_addr_write),
    .rf_write_data (rf_write_data),
    .pending_mask  (pending_mask)
`ifdef WB_SCHED_BYPASS_EN
    ,
    .fwd1_valid    (fwd1_valid),
    .fwd1_data     (fwd1_data),
    .fwd2_valid    (fwd2_valid),
    .fwd2_data     (fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [2:0]      valid;
    logic [2:0][4:0] addr;
    logic [2:0][31:0] data;
    logic            resv_v;
    reg_addr_t       resv_a;
    reg_addr_t       q1;
    reg_addr_t       q2;
    logic [2:0]      exp_ready;
  } vec_t;

  typedef struct packed {
    reg_addr_t  a;
    xlen_data_t d;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         sbq[$];
  logic [31:0] m_mask;
  reg_addr_t   m_last_a;
  xlen_data_t  m_last_d;
  vec_t        tbl[19];

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                              input logic [31:0] base, input logic rv, input logic [4:0] ra,
                              input logic [4:0] q1, input logic [4:0] q2, input logic [2:0] er);
    vec_t t;
    t.rst = r; t.valid = v;
    t.addr[0] = a0; t.addr[1] = a1; t.addr[2] = a2;
    t.data[0] = base; t.data[1] = base + 32'd1; t.data[2] = base + 32'd2;
    t.resv_v = rv; t.resv_a = ra; t.q1 = q1; t.q2 = q2; t.exp_ready = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector for one clock, checking comb outputs before the edge
  // and registered outputs after it.
  task automatic apply(input string tag, input vec_t v);
    int  g;
    wr_t e;
    logic we_exp;
    rst        = v.rst;
    req_valid  = v.valid;
    req_addr   = v.addr;
    req_data   = v.data;
    resv_valid = v.resv_v;
    resv_addr  = v.resv_a;
    query_rs1  = v.q1;
    query_rs2  = v.q2;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'(v.exp_ready));
    check({tag, " hz1"}, 32'(hz_rs1), 32'(m_mask[v.q1] && v.q1 != 0));
    check({tag, " hz2"}, 32'(hz_rs2), 32'(m_mask[v.q2] && v.q2 != 0));
    if (v.rst) begin
      sbq.delete();
      m_mask = '0; m_last_a = '0; m_last_d = '0;
    end else begin
      g = -1;
      for (int i = 0; i < 3; i++) if (v.exp_ready[i]) g = i;
      if (g >= 0 && v.addr[g] != 0) begin
        sbq.push_back({v.addr[g], v.data[g]});
        m_mask[v.addr[g]] = 1'b0;
      end
      if (v.resv_v && v.resv_a != 0) m_mask[v.resv_a] = 1'b1;
    end
    @(posedge clk);
    #1;
    we_exp = 1'b0;
    e = '0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      we_exp = 1'b1;
      m_last_a = e.a; m_last_d = e.d;
    end
    check({tag, " rf_we"}, 32'(rf_readWrite), 32'(we_exp));
    check({tag, " rf_addr"}, 32'(rf_addr_write), 32'(m_last_a));
    check({tag, " rf_data"}, rf_write_data, m_last_d);
    check({tag, " mask"}, pending_mask, m_mask);
`ifdef WB_SCHED_BYPASS_EN
    check({tag, " fwd1_v"}, 32'(fwd1_valid), 32'(we_exp && e.a == v.q1 && v.q1 != 0));
    check({tag, " fwd1_d"}, fwd1_data, (we_exp && e.a == v.q1 && v.q1 != 0) ? e.d : 32'd0);
    check({tag, " fwd2_v"}, 32'(fwd2_valid), 32'(we_exp && e.a == v.q2 && v.q2 != 0));
    check({tag, " fwd2_d"}, fwd2_data, (we_exp && e.a == v.q2 && v.q2 != 0) ? e.d : 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_mask = '0; m_last_a = '0; m_last_d = '0;
    // rst, valid, a2,a1,a0, base, resv_v, resv_a, q1, q2, exp_ready
    tbl[0]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0100, 0, 0, 0, 0, 3'b001);
    tbl[1]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0200, 0, 0, 0, 0, 3'b010);
    tbl[2]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0300, 0, 0, 0, 0, 3'b100);
    tbl[3]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0400, 0, 0, 0, 0, 3'b001);
    tbl[4]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0500, 0, 0, 0, 0, 3'b010);
    tbl[5]  = mk(0, 3'b111, 3, 2, 1, 32'h0000_0600, 0, 0, 0, 0, 3'b100);
    tbl[6]  = mk(0, 3'b000, 0, 0, 0, 32'h0,         1, 5, 5, 0, 3'b000);
    tbl[7]  = mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 5, 0, 3'b000);
    tbl[8]  = mk(0, 3'b010, 0, 5, 0, 32'hDEAD_BEEE, 0, 0, 5, 0, 3'b010);
    tbl[9]  = mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 5, 0, 3'b000);
    tbl[10] = mk(0, 3'b100, 7, 0, 0, 32'h0000_0700, 1, 7, 0, 7, 3'b100);
    tbl[11] = mk(0, 3'b000, 0, 0, 0, 32'h0,         0, 0, 0, 7, 3'b000);
    tbl[12] = mk(0, 3'b100, 0, 0, 0, 32'h0000_1232, 1, 0, 0, 0, 3'b100);
    tbl[13] = mk(0, 3'b101, 6, 0, 4, 32'h0000_1300, 0, 0, 0, 0, 3'b001);
    tbl[14] = mk(0, 3'b101, 6, 0, 4, 32'h0000_1400, 0, 0, 0, 0, 3'b100);
    tbl[15] = mk(0, 3'b000, 0, 0, 0, 32'h0,         1, 7, 7, 0, 3'b000);
    tbl[16] = mk(0, 3'b001, 0, 0, 7, 32'h0000_1600, 0, 0, 7, 0, 3'b001);
    tbl[17] = mk(0, 3'b010, 0, 9, 0, 32'hCAFE_F00C, 0, 0, 0, 9, 3'b010);
    tbl[18] = mk(0, 3'b010, 0, 9, 0, 32'h0000_1800, 0, 0, 0, 0, 3'b010);

    // Reset with every requester asking: no grants, all outputs cleared.
    apply("rst0", mk(1, 3'b111, 3, 2, 1, 32'h0, 0, 0, 0, 0, 3'b000));
    apply("rst1", mk(1, 3'b111, 3, 2, 1, 32'h0, 0, 0, 0, 0, 3'b000));

    for (int n = 0; n < 19; n++) apply($sformatf("vec%0d", n), tbl[n]);

    // Mid-operation reset right after a grant to requester 0.
    apply("mrA", mk(0, 3'b001, 3, 2, 11, 32'h0000_2000, 1, 10, 0, 0, 3'b001));
    apply("mrB", mk(1, 3'b111, 3, 2, 1,  32'h0000_2100, 1, 12, 0, 0, 3'b000));
    apply("mrC", mk(0, 3'b111, 3, 2, 1,  32'h0000_2200, 0, 0,  0, 0, 3'b001));
    apply("mrD", mk(0, 3'b000, 0, 0, 0,  32'h0,         0, 0,  0, 0, 3'b000));

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
